// File: rtl/serial_bit_packer_pkg.sv
// -----------------------------------------------------------------------------
// serial_bit_packer_pkg
//   Shared sizing helpers for the serial bit packer and its output buffer.
//   - MAX_WIDTH : largest supported packed word width
//   - cnt_w()   : width of a bit-count field able to hold 0..width
//   - word_w()  : total width of a packed {count, data} word
//   - width_ok(): legality check for the WIDTH parameter
// -----------------------------------------------------------------------------
package serial_bit_packer_pkg;

  localparam int unsigned MAX_WIDTH = 32'd32;

  // Number of bits needed to represent any count from 0 up to and including width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 32'd1);
  endfunction

  // A buffered word carries its data bits plus its valid-bit count.
  function automatic int unsigned word_w(input int unsigned width);
    return width + cnt_w(width);
  endfunction

  // Word widths outside 1..MAX_WIDTH are not supported.
  function automatic bit width_ok(input int unsigned width);
    return (width >= 32'd1) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/serial_bit_packer_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo_2
//   Generic two-entry in-order synchronous FIFO. The head entry sits in a flop
//   and is presented directly on head_data; it reads as zero when the FIFO is
//   empty so the consumer sees a clean bus while nothing is valid.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     push       : write push_data (ignored while full)
//     push_data  : entry to write
//     pop        : remove head entry (ignored while empty)
//     head_data  : current head entry (registered)
//     full/empty : registered occupancy flags
// -----------------------------------------------------------------------------
module word_fifo_2 #(
  parameter int unsigned DW = 32'd8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] slot0_q, slot0_d;
  logic [DW-1:0] slot1_q, slot1_d;
  logic [1:0]    occ_q, occ_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push;
  logic          do_pop;

  // Next-state for the two slots; slot0 is always the head, slot1 the tail.
  always_comb begin
    do_push = push & ~full_q;
    do_pop  = pop & ~empty_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          slot0_d = push_data;
        end else begin
          slot1_d = push_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        // Vacated slot is zeroed so an empty head always reads as zero.
        slot0_d = slot1_q;
        slot1_d = {DW{1'b0}};
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        // Pop needs a non-empty FIFO and push a non-full one, so occupancy
        // is exactly 1 here: the new entry replaces the departing head.
        slot0_d = push_data;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
    full_d  = (occ_d == 2'd2);
    empty_d = (occ_d == 2'd0);
  end

  // Storage and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= {DW{1'b0}};
      slot1_q <= {DW{1'b0}};
      occ_q   <= 2'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign head_data = slot0_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/serial_bit_packer.sv
// -----------------------------------------------------------------------------
// serial_bit_packer
//   Packs a 1-bit valid/ready stream LSB-first into WIDTH-bit words and offers
//   them on a valid/ready output through a two-entry buffer. up_last closes a
//   word early; the word is zero-padded above its last bit and carries its
//   bit count.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     up_valid    : serial bit present
//     up_data     : serial bit value
//     up_last     : accepted bit ends the current word
//     up_ready    : a bit can be accepted this cycle
//     down_valid  : packed word available
//     down_data   : packed word, bit 0 = first accepted bit
//     down_count  : number of valid bits in down_data (1..WIDTH)
//     down_ready  : downstream takes the word this cycle
// -----------------------------------------------------------------------------
module serial_bit_packer
  import serial_bit_packer_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_valid,
  input  logic                     up_data,
  input  logic                     up_last,
  output logic                     up_ready,
  output logic                     down_valid,
  output logic [WIDTH-1:0]         down_data,
  output logic [cnt_w(WIDTH)-1:0]  down_count,
  input  logic                     down_ready
);

  localparam int unsigned CNT_W  = cnt_w(WIDTH);
  localparam int unsigned WORD_W = word_w(WIDTH);

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data;
  } word_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] merged;
  logic             accept;
  logic             complete;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  word_t            push_word;
  word_t            head_word;

  // Accept/merge the incoming bit and decide whether it closes the word.
  always_comb begin
    accept    = up_valid & up_ready;
    complete  = (cnt_q == CNT_W'(WIDTH - 32'd1)) | up_last;
    merged    = {WIDTH{1'b0}};
    // Positions above the new bit are forced to zero so early-closed words
    // are padded regardless of accumulator contents.
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i < int'(cnt_q)) begin
        merged[i] = acc_q[i];
      end else if (i == int'(cnt_q)) begin
        merged[i] = up_data;
      end else begin
        merged[i] = 1'b0;
      end
    end
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    fifo_push       = 1'b0;
    push_word.data  = merged;
    push_word.count = cnt_q + CNT_W'(1);
    if (accept) begin
      if (complete) begin
        fifo_push = 1'b1;
        acc_d     = {WIDTH{1'b0}};
        cnt_d     = {CNT_W{1'b0}};
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      fifo_push = 1'b0;
    end
  end

  // Bit position and partial-word accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
      acc_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  word_fifo_2 #(
    .DW (WORD_W)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (down_ready),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Ready depends only on the registered full flag, never on down_ready.
  assign up_ready   = ~rst & ~fifo_full;
  assign down_valid = ~fifo_empty;
  assign down_data  = head_word.data;
  assign down_count = head_word.count;

endmodule

// File: tb/tb_serial_bit_packer.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_packer
//   Randomised and directed stimulus for serial_bit_packer (WIDTH=8), checked
//   every cycle against a queue-based reference model of the packing rules.
// -----------------------------------------------------------------------------
module tb_serial_bit_packer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  typedef struct {
    int data;
    int count;
  } word_rec_t;

  logic             clk;
  logic             rst;
  logic             up_valid;
  logic             up_data;
  logic             up_last;
  logic             up_ready;
  logic             down_valid;
  logic [WIDTH-1:0] down_data;
  logic [CW-1:0]    down_count;
  logic             down_ready;

  int n_checks;
  int n_errors;
  int n_accepted;

  word_rec_t q_exp[$];     // words the model says are buffered, head first
  word_rec_t got_words[$]; // words observed leaving the DUT
  int        part[$];      // bits of the word currently being assembled
  logic      stim_bit[$];
  logic      stim_last[$];

  serial_bit_packer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_last    (up_last),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_count (down_count),
    .down_ready (down_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference packing rule: a word closes at WIDTH bits or on last.
  task automatic model_bit(input logic d, input logic l);
    word_rec_t w;
    part.push_back(int'(d));
    if (part.size() == int'(WIDTH) || l) begin
      w.data  = 0;
      foreach (part[i]) w.data += part[i] << i;
      w.count = part.size();
      q_exp.push_back(w);
      part.delete();
    end
  endtask

  // One clock: drive at the falling edge, check, then advance the model.
  task automatic cycle(input logic v, input logic d, input logic l, input logic r,
                       output logic acc);
    logic      exp_rdy;
    logic      exp_vld;
    word_rec_t g;
    up_valid   = v;
    up_data    = d;
    up_last    = l;
    down_ready = r;
    #1;
    exp_rdy = (q_exp.size() < 2);
    exp_vld = (q_exp.size() != 0);
    check_eq("up_ready", 32'(up_ready), 32'(exp_rdy));
    check_eq("down_valid", 32'(down_valid), 32'(exp_vld));
    if (exp_vld) begin
      check_eq("down_data", 32'(down_data), 32'(q_exp[0].data));
      check_eq("down_count", 32'(down_count), 32'(q_exp[0].count));
    end else begin
      check_eq("idle_data", 32'(down_data), 32'd0);
      check_eq("idle_count", 32'(down_count), 32'd0);
    end
    acc = v && exp_rdy;
    if (exp_vld && r) begin
      g.data  = int'(down_data);
      g.count = int'(down_count);
      got_words.push_back(g);
      void'(q_exp.pop_front());
    end
    if (acc) begin
      n_accepted++;
      model_bit(d, l);
    end
    @(negedge clk);
  endtask

  // Queue n bits of val LSB-first; optionally mark the final one as last.
  task automatic load_bits(input logic [31:0] val, input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      stim_bit.push_back(val[i]);
      stim_last.push_back(last_at_end && (i == n - 1));
    end
  endtask

  // rdy_mode 0: ready always; 1: ready only from cycle hold0; 2: random ready.
  task automatic run_stream(input int rdy_mode, input int hold0, input int gap_pct,
                            input bit drain);
    int   cyc;
    logic v, d, l, r, acc;
    cyc = 0;
    while ((stim_bit.size() != 0 || (drain && q_exp.size() != 0)) && cyc < 5000) begin
      v = (stim_bit.size() != 0) && ($urandom_range(99) >= gap_pct);
      d = v ? stim_bit[0]  : 1'($urandom);
      l = v ? stim_last[0] : 1'($urandom);
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (cyc >= hold0);
        default: r = ($urandom_range(99) < 70);
      endcase
      cycle(v, d, l, r, acc);
      if (acc) begin
        void'(stim_bit.pop_front());
        void'(stim_last.pop_front());
      end
      cyc++;
    end
    if (cyc >= 5000) check_eq("stream_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    logic acc;
    n_checks   = 0;
    n_errors   = 0;
    n_accepted = 0;
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = 1'b0;
    up_last    = 1'b0;
    down_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_down_valid", 32'(down_valid), 32'd0);
    check_eq("rst_up_ready", 32'(up_ready), 32'd0);
    check_eq("rst_down_data", 32'(down_data), 32'd0);
    check_eq("rst_down_count", 32'(down_count), 32'd0);
    rst = 1'b0;

    // Full word back to back: bits 1,0,1,1,0,0,1,0 -> 0x4D.
    got_words.delete();
    load_bits(32'h4D, 8, 1'b0);
    run_stream(0, 0, 0, 1'b1);
    check_eq("w1_words", 32'(got_words.size()), 32'd1);
    if (got_words.size() >= 1) begin
      check_eq("w1_data", 32'(got_words[0].data), 32'h4D);
      check_eq("w1_count", 32'(got_words[0].count), 32'd8);
    end

    // Early close after 3 bits, then a 1-bit word.
    got_words.delete();
    load_bits(32'h7, 3, 1'b1);
    load_bits(32'h1, 1, 1'b1);
    run_stream(0, 0, 0, 1'b1);
    check_eq("short_words", 32'(got_words.size()), 32'd2);
    if (got_words.size() >= 2) begin
      check_eq("short0_data", 32'(got_words[0].data), 32'h07);
      check_eq("short0_count", 32'(got_words[0].count), 32'd3);
      check_eq("short1_data", 32'(got_words[1].data), 32'h01);
      check_eq("short1_count", 32'(got_words[1].count), 32'd1);
    end

    // last on the 8th bit yields exactly one full word.
    got_words.delete();
    load_bits(32'hA5, 8, 1'b1);
    run_stream(0, 0, 0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
    check_eq("last8_words", 32'(got_words.size()), 32'd1);
    if (got_words.size() >= 1) begin
      check_eq("last8_data", 32'(got_words[0].data), 32'hA5);
      check_eq("last8_count", 32'(got_words[0].count), 32'd8);
    end

    // Back-pressure: 24 alternating bits with down_ready low for 30 cycles.
    got_words.delete();
    n_accepted = 0;
    load_bits(32'h555555, 24, 1'b0);
    run_stream(1, 30, 0, 1'b1);
    check_eq("bp_accepted", 32'(n_accepted), 32'd24);
    check_eq("bp_words", 32'(got_words.size()), 32'd3);
    foreach (got_words[i]) begin
      check_eq("bp_data", 32'(got_words[i].data), 32'h55);
      check_eq("bp_count", 32'(got_words[i].count), 32'd8);
    end

    // Asynchronous reset with a buffered word and a 5-bit partial word.
    load_bits(32'h1FFF, 13, 1'b0);
    run_stream(1, 100000, 0, 1'b0);
    check_eq("pre_rst_valid", 32'(down_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(down_valid), 32'd0);
    check_eq("async_rst_ready", 32'(up_ready), 32'd0);
    q_exp.delete();
    part.delete();
    got_words.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    load_bits(32'hFF, 8, 1'b0);
    run_stream(0, 0, 0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
    check_eq("post_rst_words", 32'(got_words.size()), 32'd1);
    if (got_words.size() >= 1) begin
      check_eq("post_rst_data", 32'(got_words[0].data), 32'hFF);
      check_eq("post_rst_count", 32'(got_words[0].count), 32'd8);
    end

    // 64 continuous random bits at full rate.
    got_words.delete();
    for (int i = 0; i < 64; i++) begin
      stim_bit.push_back(1'($urandom));
      stim_last.push_back(1'b0);
    end
    run_stream(0, 0, 0, 1'b1);
    check_eq("rate_words", 32'(got_words.size()), 32'd8);

    // Random gaps, random early closes and random back-pressure.
    for (int i = 0; i < 400; i++) begin
      stim_bit.push_back(1'($urandom));
      stim_last.push_back((i == 399) || ($urandom_range(5) == 0));
    end
    run_stream(2, 0, 20, 1'b1);
    check_eq("rand_drained", 32'(q_exp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_packer.md
Name: serial_bit_packer

Overview:
- Downstream stage for the single-bit gate/mux datapath blocks.
- Consumes a 1-bit serial stream under a valid/ready handshake and packs it LSB-first into WIDTH-bit words.
- Presents the words on a valid/ready output with a 2-entry buffer, so one bit per cycle is sustained when downstream is ready.
- up_last closes a partial word early; the word is zero-padded and reports its bit count.

Parameters:
- WIDTH, 8, output word width in bits (legal range 1..32).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- up_valid  input  1  serial bit present
- up_data  input  1  serial bit value
- up_last  input  1  accepted bit is the final bit of the current word
- up_ready  output  1  block can accept a bit this cycle
- down_valid  output  1  packed word available
- down_data  output  WIDTH  packed word, bit 0 = first accepted bit
- down_count  output  $clog2(WIDTH+1)  number of valid bits in down_data (1..WIDTH)
- down_ready  input  1  downstream accepts the word this cycle

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: down_valid=0, down_data=0, down_count=0, up_ready=0 while rst is high. Internal bit position cnt=0, accumulator=0, FIFO empty.
- up_ready = !rst && !fifo_full. It is a function of registered state only, with no combinational path from down_ready.
- Bit acceptance: an up_valid && up_ready edge writes up_data into accumulator[cnt].
- Word completion: the word completes when an accepted bit has cnt==WIDTH-1 or up_last=1.
  - On completion, push {accumulator with the new bit, bits above cnt forced to 0, count=cnt+1} into the FIFO.
  - Clear the accumulator and set cnt=0 in the same edge.
  - Otherwise cnt increments.
- up_last with cnt==WIDTH-1 produces exactly one word with count WIDTH. No trailing empty word.
- up_last on the first bit produces count 1.
- Latency: down_valid rises on the cycle after the completing bit's acceptance edge.
- FIFO: 2 entries, in order. Pop on down_valid && down_ready.
- Simultaneous push and pop at occupancy 1 leaves occupancy 1 with the new word at the head next cycle.
- Push cannot occur when full, because up_ready=0.
- While down_valid && !down_ready, down_data and down_count hold stable.
- When not valid, down_data and down_count are don't-care; the implementation drives 0.
- Throughput: with down_ready held 1, up_ready never deasserts, giving 1 bit/cycle.
- With down_ready=0: up_ready drops the cycle after the second word is pushed. Bits of the next word stall in the upstream, and no bit is lost or duplicated.
- Reset mid-word or with the FIFO non-empty: all partial and buffered data is discarded. After deassertion, the first accepted bit lands at position 0.
- WIDTH=1: every accepted bit is a complete word with count 1.
- Inputs up_data and up_last are ignored when up_valid=0.

Decomposition:
- Package serial_bit_packer_pkg holds:
  - the CNT_W = $clog2(WIDTH+1) helper function;
  - the word_t typedef (struct of data and count), parameterised via a function or localparam in the module.
- Sub-module word_fifo_2 is a generic 2-entry synchronous FIFO with push/pop/full/empty and async active-high reset, instantiated once for the output buffer.
- Packing counter and accumulator stay in the top.

Test Plan:
- WIDTH=8, down_ready=1, bits 1,0,1,1,0,0,1,0 back-to-back -> one word down_data=0x4D, down_count=8, down_valid high exactly 1 cycle, the cycle after the 8th bit.
- Bits 1,1,1 with up_last on the 3rd -> down_data=0x07, down_count=3; next stream bit 1 with up_last -> down_data=0x01, down_count=1.
- 8th bit sent with up_last=1 -> single word count 8, no extra word.
- down_ready=0, 24 continuous bits of alternating 1,0 -> two words 0x55 buffered, then up_ready=0 from the cycle after the 16th accepted bit. Raise down_ready -> words 0x55, 0x55, 0x55 delivered in order, 24 bits total accepted.
- 5 bits accepted, pulse rst asynchronously mid-cycle -> down_valid and up_ready go 0 immediately. Then send 8 bits 0xFF LSB-first -> exactly one word 0xFF, count 8, no remnant of the pre-reset bits.
- 64 continuous bits, down_ready=1 -> 8 words in order, up_ready never 0, one word every 8 cycles.
